// File: rtl/seq_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package seq_adder_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter is at least one bit wide even when a single digit covers the word.
  function automatic int calc_cnt_w(input int width, input int digit);
    int n;
    n = width / digit;
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/seq_adder_digit_add.sv
// Combinational DIGIT-bit ripple-carry adder used once per clock by seq_adder.
module digit_add #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic [DIGIT:0] c_s;

  // Ripple the carry from bit 0 upwards.
  always_comb begin
    c_s    = '0;
    s      = '0;
    c_s[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]       = a[i] ^ b[i] ^ c_s[i];
      c_s[i+1]   = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end
    cout = c_s[DIGIT];
  end

endmodule

// File: rtl/seq_adder.sv
// WIDTH-bit adder processing DIGIT bits per clock with start/busy/done handshake.
// Optional subtraction (sub port) is built when SEQ_ADDER_SUB_EN is defined.
module seq_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEQ_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int CW   = calc_cnt_w(WIDTH, DIGIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic                   sub_s;
  logic [WIDTH-1:0]       b_eff_s;
  logic                   cin_eff_s;
  logic [DIGIT-1:0]       dig_s;
  logic                   dig_cout_s;
  logic [WIDTH+DIGIT-1:0] acc_cat_s;
  logic [WIDTH-1:0]       acc_shift_s;

`ifdef SEQ_ADDER_SUB_EN
  assign sub_s = sub;
`else
  assign sub_s = 1'b0;
`endif

  // Subtraction is a + ~b + 1, so the incoming carry is forced high.
  assign b_eff_s   = sub_s ? ~b : b;
  assign cin_eff_s = sub_s ? 1'b1 : cin;

  digit_add #(.DIGIT(DIGIT)) u_digit_add (
    .a    (a_sh_q[DIGIT-1:0]),
    .b    (b_sh_q[DIGIT-1:0]),
    .cin  (carry_q),
    .s    (dig_s),
    .cout (dig_cout_s)
  );

  // New digit enters at the top; after NDIG shifts the first digit sits at bit 0.
  assign acc_cat_s   = {dig_s, acc_q};
  assign acc_shift_s = acc_cat_s[WIDTH+DIGIT-1:DIGIT];

  // Next-state logic for the IDLE/RUN controller and datapath registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b_eff_s;
          carry_d = cin_eff_s;
          cnt_d   = '0;
          acc_d   = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b_eff_s[WIDTH-1];
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        acc_d   = acc_shift_s;
        carry_d = dig_cout_s;
        if (cnt_q == CNT_LAST) begin
          sum_d   = acc_shift_s;
          cout_d  = dig_cout_s;
          ovf_d   = (a_msb_q == b_msb_q) && (acc_shift_s[WIDTH-1] != a_msb_q);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = ST_RUN;
        end
      end
      default: begin
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_adder.sv
// Directed self-checking bench for seq_adder (WIDTH=16, DIGIT=4).
module tb_seq_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
`ifdef SEQ_ADDER_SUB_EN
  logic        sub;
`endif
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int chk_pass;
  int chk_total;

  seq_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SEQ_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Pulse start for one edge, then wait four edges; returns #1 into the done cycle.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else chk_pass++;
    chk_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b exp 0", done); else chk_pass++;
    chk_total++; if (sum !== 16'h0000) $display("FAIL reset_sum: got %h exp 0000", sum); else chk_pass++;
    chk_total++; if (cout !== 1'b0) $display("FAIL reset_cout: got %b exp 0", cout); else chk_pass++;
    chk_total++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b exp 0", ovf); else chk_pass++;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_plain_add();
    int busy_cnt;
    busy_cnt = 0;
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (busy === 1'b1 && done === 1'b0) busy_cnt++;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (busy === 1'b1 && done === 1'b0) busy_cnt++;
    end
    chk_total++; if (busy_cnt != 4) $display("FAIL plain_busy_cycles: got %0d exp 4", busy_cnt); else chk_pass++;
    @(posedge clk); #1;
    chk_total++; if (done !== 1'b1) $display("FAIL plain_done_edge4: got %b exp 1", done); else chk_pass++;
    chk_total++; if (busy !== 1'b0) $display("FAIL plain_busy_end: got %b exp 0", busy); else chk_pass++;
    chk_total++; if (sum !== 16'h5555) $display("FAIL plain_sum: got %h exp 5555", sum); else chk_pass++;
    chk_total++; if (cout !== 1'b0 || ovf !== 1'b0) $display("FAIL plain_flags: got cout=%b ovf=%b exp 0 0", cout, ovf); else chk_pass++;
    @(posedge clk); #1;
    chk_total++; if (done !== 1'b0) $display("FAIL plain_done_pulse: got %b exp 0", done); else chk_pass++;
  endtask

  task automatic test_carry_wrap();
    run_op(16'hFFFF, 16'h0001, 1'b0);
    chk_total++; if (done !== 1'b1) $display("FAIL wrap_done: got %b exp 1", done); else chk_pass++;
    chk_total++; if (sum !== 16'h0000) $display("FAIL wrap_sum: got %h exp 0000", sum); else chk_pass++;
    chk_total++; if (cout !== 1'b1 || ovf !== 1'b0) $display("FAIL wrap_flags: got cout=%b ovf=%b exp 1 0", cout, ovf); else chk_pass++;
    run_op(16'h7FFF, 16'h0000, 1'b1);
    chk_total++; if (sum !== 16'h8000) $display("FAIL ovf_sum: got %h exp 8000", sum); else chk_pass++;
    chk_total++; if (cout !== 1'b0 || ovf !== 1'b1) $display("FAIL ovf_flags: got cout=%b ovf=%b exp 0 1", cout, ovf); else chk_pass++;
    @(negedge clk);
  endtask

  task automatic test_handshake();
    int hold_cnt;
    hold_cnt = 0;
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    // Ignored start, with operands changed after capture.
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    chk_total++; if (done !== 1'b0) $display("FAIL hs_done_early: got %b exp 0", done); else chk_pass++;
    @(posedge clk); #1;
    chk_total++; if (done !== 1'b1 || sum !== 16'h5555) $display("FAIL hs_first_result: got done=%b sum=%h exp 1 5555", done, sum); else chk_pass++;
    // Start in the done cycle.
    a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (sum === 16'h5555 && done === 1'b0) hold_cnt++;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (sum === 16'h5555 && done === 1'b0) hold_cnt++;
    end
    chk_total++; if (hold_cnt != 4) $display("FAIL hs_sum_hold: got %0d cycles exp 4", hold_cnt); else chk_pass++;
    @(posedge clk); #1;
    chk_total++; if (done !== 1'b1 || sum !== 16'h0002) $display("FAIL hs_b2b_result: got done=%b sum=%h exp 1 0002", done, sum); else chk_pass++;
    @(posedge clk); #1;
    chk_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL hs_no_queue: got busy=%b done=%b exp 0 0", busy, done); else chk_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    logic done_seen;
    done_seen = 1'b0;
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midrst_ctrl: got busy=%b done=%b exp 0 0", busy, done); else chk_pass++;
    chk_total++; if (sum !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0) $display("FAIL midrst_result: got sum=%h cout=%b ovf=%b exp 0000 0 0", sum, cout, ovf); else chk_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen = 1'b1;
    end
    chk_total++; if (done_seen !== 1'b0 || sum !== 16'h0000) $display("FAIL midrst_no_done: got done_seen=%b sum=%h exp 0 0000", done_seen, sum); else chk_pass++;
    @(negedge clk);
  endtask

`ifdef SEQ_ADDER_SUB_EN
  task automatic test_sub();
    sub = 1'b1;
    run_op(16'h0005, 16'h0007, 1'b1);
    chk_total++; if (sum !== 16'hFFFE) $display("FAIL sub_small_sum: got %h exp fffe", sum); else chk_pass++;
    chk_total++; if (cout !== 1'b0 || ovf !== 1'b0) $display("FAIL sub_small_flags: got cout=%b ovf=%b exp 0 0", cout, ovf); else chk_pass++;
    run_op(16'h8000, 16'h0001, 1'b0);
    chk_total++; if (sum !== 16'h7FFF) $display("FAIL sub_ovf_sum: got %h exp 7fff", sum); else chk_pass++;
    chk_total++; if (cout !== 1'b1 || ovf !== 1'b1) $display("FAIL sub_ovf_flags: got cout=%b ovf=%b exp 1 1", cout, ovf); else chk_pass++;
    sub = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    chk_pass = 0; chk_total = 0;
    clk = 1'b0; rst_n = 1'b0; start = 1'b0;
    a = 16'h0000; b = 16'h0000; cin = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
    sub = 1'b0;
`endif
    test_reset();
    test_plain_add();
    test_carry_wrap();
    test_handshake();
    test_reset_mid_op();
`ifdef SEQ_ADDER_SUB_EN
    test_sub();
`endif
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
